// File: rtl/fir_axil_pkg.sv
// Register map, status bit positions, error codes and state encodings shared by the
// FIR configuration master and its AXI4-Lite transaction engine.
package fir_axil_pkg;

  localparam int unsigned ADDR_AP_CTRL  = 32'h00;
  localparam int unsigned ADDR_DATA_LEN = 32'h10;
  localparam int unsigned ADDR_TAP_BASE = 32'h40;

  localparam int unsigned AP_START_BIT = 0;
  localparam int unsigned AP_DONE_BIT  = 1;
  localparam int unsigned AP_IDLE_BIT  = 2;

  typedef enum logic [1:0] {
    ErrNone        = 2'd0,
    ErrIdleTimeout = 2'd1,
    ErrVerify      = 2'd2,
    ErrDoneTimeout = 2'd3
  } cfg_err_e;

  typedef enum logic [2:0] {
    StIdle,
    StPollIdle,
    StWrLen,
    StWrTap,
    StRdTap,
    StWrStart,
    StPollDone,
    StFinish
  } cfg_state_e;

  typedef enum logic [1:0] {
    XactIdle,
    XactWrite,
    XactRdAddr,
    XactRdData
  } xact_state_e;

  function automatic int unsigned tap_addr(input logic [3:0] idx);
    return ADDR_TAP_BASE + 4 * 32'(idx);
  endfunction

endpackage

// File: rtl/axil_master_xact.sv
// Single AXI4-Lite read or write per request. ack pulses in the completion cycle; for
// reads rsp_rdata is valid in that same cycle.
module axil_master_xact
  import fir_axil_pkg::*;
#(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   req,
  input  logic                   req_write,
  input  logic [pADDR_WIDTH-1:0] req_addr,
  input  logic [pDATA_WIDTH-1:0] req_wdata,
  output logic                   ack,
  output logic [pDATA_WIDTH-1:0] rsp_rdata,
  output logic [pADDR_WIDTH-1:0] awaddr,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [pDATA_WIDTH-1:0] wdata,
  output logic                   wvalid,
  input  logic                   wready,
  output logic [pADDR_WIDTH-1:0] araddr,
  output logic                   arvalid,
  input  logic                   arready,
  input  logic [pDATA_WIDTH-1:0] rdata,
  input  logic                   rvalid,
  output logic                   rready
);

  xact_state_e            xst_q, xst_d;
  logic [pADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [pDATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                   awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic                   arvalid_q, arvalid_d, rready_q, rready_d;

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      xst_q     <= XactIdle;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      xst_q     <= xst_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
    end
  end

  always_comb begin
    xst_d     = xst_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    ack       = 1'b0;
    unique case (xst_q)
      XactIdle: begin
        if (req && req_write) begin
          awaddr_d  = req_addr;
          wdata_d   = req_wdata;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          xst_d     = XactWrite;
        end else if (req) begin
          araddr_d  = req_addr;
          arvalid_d = 1'b1;
          xst_d     = XactRdAddr;
        end
      end
      XactWrite: begin
        // A dropped valid means that channel already handshook in an earlier cycle.
        if (awvalid_q && awready) awvalid_d = 1'b0;
        if (wvalid_q && wready)   wvalid_d  = 1'b0;
        if ((!awvalid_q || awready) && (!wvalid_q || wready)) begin
          ack   = 1'b1;
          xst_d = XactIdle;
        end
      end
      XactRdAddr: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          xst_d     = XactRdData;
        end
      end
      XactRdData: begin
        if (rvalid) begin
          rready_d = 1'b0;
          ack      = 1'b1;
          xst_d    = XactIdle;
        end
      end
      default: xst_d = XactIdle;
    endcase
  end

  assign rsp_rdata = rdata;
  assign awaddr    = awaddr_q;
  assign awvalid   = awvalid_q;
  assign wdata     = wdata_q;
  assign wvalid    = wvalid_q;
  assign araddr    = araddr_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;

endmodule

// File: rtl/fir_cfg_master.sv
// Sequences FIR engine setup over AXI4-Lite: wait idle, write length and taps (optional
// readback), set ap_start, then poll for ap_done.
module fir_cfg_master
  import fir_axil_pkg::*;
#(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned Tape_Num    = 11,
  parameter int unsigned pPOLL_LIMIT = 1024
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   cfg_start,
  input  logic [31:0]            cfg_data_length,
  input  logic                   cfg_verify,
  output logic                   cfg_busy,
  output logic                   cfg_done,
  output logic [1:0]             cfg_error,
  output logic [3:0]             coef_idx,
  input  logic [31:0]            coef_data,
  output logic [pADDR_WIDTH-1:0] awaddr,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [pDATA_WIDTH-1:0] wdata,
  output logic                   wvalid,
  input  logic                   wready,
  output logic [pADDR_WIDTH-1:0] araddr,
  output logic                   arvalid,
  input  logic                   arready,
  input  logic [pDATA_WIDTH-1:0] rdata,
  input  logic                   rvalid,
  output logic                   rready
);

  localparam int unsigned      PollW    = $clog2(pPOLL_LIMIT + 1);
  localparam logic [PollW-1:0] PollLast = PollW'(pPOLL_LIMIT - 1);
  localparam logic [3:0]       LastTap  = 4'(Tape_Num - 1);

  cfg_state_e       state_q, state_d;
  cfg_err_e         err_q, err_d;
  logic [3:0]       tap_q, tap_d, coef_idx_q, coef_idx_d;
  logic [PollW-1:0] poll_q, poll_d;
  logic [31:0]      len_q, len_d;
  logic             verify_q, verify_d, fetch_q, fetch_d;
  logic             tap_done;

  logic                   req, req_write, ack;
  logic [pADDR_WIDTH-1:0] req_addr;
  logic [pDATA_WIDTH-1:0] req_wdata, rsp_rdata;

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state_q    <= StIdle;
      err_q      <= ErrNone;
      tap_q      <= '0;
      coef_idx_q <= '0;
      poll_q     <= '0;
      len_q      <= '0;
      verify_q   <= 1'b0;
      fetch_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      tap_q      <= tap_d;
      coef_idx_q <= coef_idx_d;
      poll_q     <= poll_d;
      len_q      <= len_d;
      verify_q   <= verify_d;
      fetch_q    <= fetch_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    tap_d      = tap_q;
    coef_idx_d = coef_idx_q;
    poll_d     = poll_q;
    len_d      = len_q;
    verify_d   = verify_q;
    fetch_d    = fetch_q;
    tap_done   = 1'b0;
    req        = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    // req is held for the whole state; the engine only samples it while idle.
    unique case (state_q)
      StIdle: begin
        if (cfg_start) begin
          state_d  = StPollIdle;
          err_d    = ErrNone;
          len_d    = cfg_data_length;
          verify_d = cfg_verify;
          poll_d   = '0;
        end
      end
      StPollIdle: begin
        req      = 1'b1;
        req_addr = pADDR_WIDTH'(ADDR_AP_CTRL);
        if (ack) begin
          if (rsp_rdata[AP_IDLE_BIT]) begin
            state_d = StWrLen;
          end else if (poll_q == PollLast) begin
            err_d   = ErrIdleTimeout;
            state_d = StFinish;
          end else begin
            poll_d = poll_q + 1'b1;
          end
        end
      end
      StWrLen: begin
        req       = 1'b1;
        req_write = 1'b1;
        req_addr  = pADDR_WIDTH'(ADDR_DATA_LEN);
        req_wdata = pDATA_WIDTH'(len_q);
        if (ack) begin
          state_d    = StWrTap;
          tap_d      = '0;
          coef_idx_d = '0;
          fetch_d    = 1'b1;
        end
      end
      StWrTap: begin
        // First cycle only lets the registered ROM catch up with coef_idx.
        if (fetch_q) begin
          fetch_d = 1'b0;
        end else begin
          req       = 1'b1;
          req_write = 1'b1;
          req_addr  = pADDR_WIDTH'(tap_addr(tap_q));
          req_wdata = pDATA_WIDTH'(coef_data);
          if (ack) begin
            if (verify_q) state_d = StRdTap;
            else          tap_done = 1'b1;
          end
        end
      end
      StRdTap: begin
        req      = 1'b1;
        req_addr = pADDR_WIDTH'(tap_addr(tap_q));
        if (ack) begin
          // wdata still holds the tap just written.
          if (rsp_rdata == wdata) begin
            tap_done = 1'b1;
          end else begin
            err_d   = ErrVerify;
            state_d = StFinish;
          end
        end
      end
      StWrStart: begin
        req       = 1'b1;
        req_write = 1'b1;
        req_addr  = pADDR_WIDTH'(ADDR_AP_CTRL);
        req_wdata = pDATA_WIDTH'(1 << AP_START_BIT);
        if (ack) begin
          state_d = StPollDone;
          poll_d  = '0;
        end
      end
      StPollDone: begin
        req      = 1'b1;
        req_addr = pADDR_WIDTH'(ADDR_AP_CTRL);
        if (ack) begin
          if (rsp_rdata[AP_DONE_BIT]) begin
            state_d = StFinish;
          end else if (poll_q == PollLast) begin
            err_d   = ErrDoneTimeout;
            state_d = StFinish;
          end else begin
            poll_d = poll_q + 1'b1;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (tap_done) begin
      if (tap_q == LastTap) begin
        state_d = StWrStart;
      end else begin
        tap_d      = tap_q + 4'd1;
        coef_idx_d = tap_q + 4'd1;
        fetch_d    = 1'b1;
        state_d    = StWrTap;
      end
    end
  end

  assign cfg_busy  = (state_q != StIdle) && (state_q != StFinish);
  assign cfg_done  = (state_q == StFinish);
  assign cfg_error = err_q;
  assign coef_idx  = coef_idx_q;

  axil_master_xact #(
    .pADDR_WIDTH(pADDR_WIDTH),
    .pDATA_WIDTH(pDATA_WIDTH)
  ) u_xact (
    .axis_clk (axis_clk),
    .axis_rst (axis_rst),
    .req      (req),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .ack      (ack),
    .rsp_rdata(rsp_rdata),
    .awaddr   (awaddr),
    .awvalid  (awvalid),
    .awready  (awready),
    .wdata    (wdata),
    .wvalid   (wvalid),
    .wready   (wready),
    .araddr   (araddr),
    .arvalid  (arvalid),
    .arready  (arready),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .rready   (rready)
  );

endmodule

// File: tb/tb_fir_cfg_master.sv
// Directed scenarios with randomized coefficients/lengths against a behavioural slave and
// a transaction-level expectation model of the configuration sequence.
module tb_fir_cfg_master;

  localparam int TAPS  = 11;
  localparam int LIMIT = 24;

  logic        axis_clk = 1'b0;
  logic        axis_rst;
  logic        cfg_start, cfg_verify, cfg_busy, cfg_done;
  logic [31:0] cfg_data_length, coef_data;
  logic [1:0]  cfg_error;
  logic [3:0]  coef_idx;
  logic [11:0] awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic        awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;

  fir_cfg_master #(
    .pADDR_WIDTH(12),
    .pDATA_WIDTH(32),
    .Tape_Num   (TAPS),
    .pPOLL_LIMIT(LIMIT)
  ) dut (
    .axis_clk       (axis_clk),
    .axis_rst       (axis_rst),
    .cfg_start      (cfg_start),
    .cfg_data_length(cfg_data_length),
    .cfg_verify     (cfg_verify),
    .cfg_busy       (cfg_busy),
    .cfg_done       (cfg_done),
    .cfg_error      (cfg_error),
    .coef_idx       (coef_idx),
    .coef_data      (coef_data),
    .awaddr         (awaddr),
    .awvalid        (awvalid),
    .awready        (awready),
    .wdata          (wdata),
    .wvalid         (wvalid),
    .wready         (wready),
    .araddr         (araddr),
    .arvalid        (arvalid),
    .arready        (arready),
    .rdata          (rdata),
    .rvalid         (rvalid),
    .rready         (rready)
  );

  always #5 axis_clk = ~axis_clk;

  // Coefficient ROM (registered) and behavioural AXI4-Lite slave.
  logic [31:0] rom [0:15];
  logic [31:0] mem [0:15];
  logic [11:0] aw_log [0:63];
  logic [31:0] w_log [0:63];
  int aw_n, w_n, ctrl_reads, tap_reads, done_polls, aw_wait, w_wait, done_pulses;
  int aw_delay, w_delay, slv_corrupt, slv_done_after;
  bit slv_idle, slv_clear, start_seen;
  logic rvalid_r;
  logic [31:0] rdata_r;

  always @(posedge axis_clk) coef_data <= rom[coef_idx];

  assign awready = awvalid && (aw_wait >= aw_delay);
  assign wready  = wvalid && (w_wait >= w_delay);
  assign arready = arvalid;
  assign rvalid  = rvalid_r;
  assign rdata   = rdata_r;

  always @(posedge axis_clk) begin
    if (cfg_done) done_pulses <= done_pulses + 1;
    if (slv_clear) begin
      aw_n <= 0; w_n <= 0; ctrl_reads <= 0; tap_reads <= 0;
      done_polls <= 0; start_seen <= 1'b0;
    end
    if (axis_rst) begin
      rvalid_r <= 1'b0; aw_wait <= 0; w_wait <= 0;
    end else begin
      aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
      w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
      if (awvalid && awready && aw_n < 64) begin
        aw_log[aw_n] <= awaddr; aw_n <= aw_n + 1;
      end
      if (wvalid && wready && w_n < 64) begin
        w_log[w_n] <= wdata; w_n <= w_n + 1;
        // Only one write is ever outstanding, so awaddr still names this write.
        if (awaddr == 12'h000 && wdata[0]) begin
          start_seen <= 1'b1; done_polls <= 0;
        end else if (awaddr >= 12'h040) begin
          mem[(awaddr - 12'h040) >> 2] <= wdata;
        end
      end
      if (rvalid_r && rready) rvalid_r <= 1'b0;
      if (arvalid && arready) begin
        rvalid_r <= 1'b1;
        if (araddr == 12'h000) begin
          ctrl_reads <= ctrl_reads + 1;
          rdata_r <= {29'b0, slv_idle, start_seen && (done_polls >= slv_done_after), 1'b0};
          if (start_seen && done_polls < slv_done_after) done_polls <= done_polls + 1;
        end else begin
          tap_reads <= tap_reads + 1;
          rdata_r <= (int'((araddr - 12'h040) >> 2) == slv_corrupt) ? 32'hDEAD
                                                                   : mem[(araddr - 12'h040) >> 2];
        end
      end
    end
  end

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_a [$];
  logic [31:0] exp_d [$];

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_slave();
    slv_clear = 1'b1;
    @(posedge axis_clk);
    #1 slv_clear = 1'b0;
  endtask

  // Expected transaction-level outcome from the register-sequence rules.
  task automatic build_expect(input int len, input bit verify, input bit idle_ok,
                              input int corrupt, input int dafter, output int err,
                              output int ctrl_rd, output int tap_rd, output int cyc);
    exp_a.delete(); exp_d.delete();
    tap_rd = 0;
    if (!idle_ok) begin
      err = 1; ctrl_rd = LIMIT; cyc = 3 * LIMIT;
      return;
    end
    exp_a.push_back(12'h010); exp_d.push_back(len);
    ctrl_rd = 1; cyc = 3 + 2;
    for (int i = 0; i < TAPS; i++) begin
      exp_a.push_back(12'(32'h40 + 4 * i)); exp_d.push_back(rom[i]); cyc += 3;
      if (verify) begin
        tap_rd++; cyc += 3;
        if (i == corrupt) begin
          err = 2;
          return;
        end
      end
    end
    exp_a.push_back(12'h000); exp_d.push_back(32'h1); cyc += 2;
    if (dafter >= LIMIT) begin
      err = 3; ctrl_rd += LIMIT; cyc += 3 * LIMIT;
    end else begin
      err = 0; ctrl_rd += dafter + 1; cyc += 3 * (dafter + 1);
    end
  endtask

  task automatic run(input int len, input bit verify, input int poke_at,
                     output int busy_cyc, output int err_seen, output bit done_ok);
    @(negedge axis_clk);
    cfg_start = 1'b1; cfg_data_length = len; cfg_verify = verify;
    @(negedge axis_clk);
    cfg_start = 1'b0;
    check("busy_rise", cfg_busy, 1);
    busy_cyc = 1; err_seen = -1; done_ok = 1'b0;
    for (int c = 0; c < 4000 && !done_ok; c++) begin
      if (c == poke_at) begin
        cfg_start = 1'b1; cfg_data_length = 999; cfg_verify = 1'b1;
      end else begin
        cfg_start = 1'b0;
      end
      @(negedge axis_clk);
      if (cfg_done) begin
        done_ok = 1'b1; err_seen = cfg_error;
        check("busy_low_at_done", cfg_busy, 0);
      end else if (cfg_busy) begin
        busy_cyc++;
      end
    end
    cfg_start = 1'b0;
  endtask

  task automatic scenario(input string tag, input int len, input bit verify, input bit idle,
                          input int corrupt, input int dafter, input int awd, input int wd,
                          input int poke, input bit chk_cyc);
    int e_err, e_ctrl, e_tap, e_cyc, busy_cyc, err_seen, pulses0;
    bit done_ok;
    for (int i = 0; i < 16; i++) rom[i] = $urandom;
    slv_idle = idle; slv_corrupt = corrupt; slv_done_after = dafter;
    aw_delay = awd; w_delay = wd;
    clear_slave();
    build_expect(len, verify, idle, corrupt, dafter, e_err, e_ctrl, e_tap, e_cyc);
    pulses0 = done_pulses;
    run(len, verify, poke, busy_cyc, err_seen, done_ok);
    check({tag, "_done_seen"}, done_ok, 1);
    check({tag, "_error"}, err_seen, e_err);
    if (chk_cyc) check({tag, "_busy_cycles"}, busy_cyc, e_cyc);
    @(negedge axis_clk);
    check({tag, "_error_held"}, cfg_error, e_err);
    check({tag, "_done_pulses"}, done_pulses - pulses0, 1);
    check({tag, "_aw_count"}, aw_n, exp_a.size());
    check({tag, "_w_count"}, w_n, exp_d.size());
    for (int i = 0; i < exp_a.size() && i < aw_n && i < w_n; i++) begin
      check({tag, "_waddr"}, aw_log[i], exp_a[i]);
      check({tag, "_wdata"}, w_log[i], exp_d[i]);
    end
    check({tag, "_ctrl_reads"}, ctrl_reads, e_ctrl);
    check({tag, "_tap_reads"}, tap_reads, e_tap);
  endtask

  initial begin
    int pulses0;
    bit hit;
    cfg_start = 1'b0; cfg_verify = 1'b0; cfg_data_length = '0;
    aw_delay = 0; w_delay = 0; slv_idle = 1'b1; slv_corrupt = -1; slv_done_after = 0;
    done_pulses = 0;
    for (int i = 0; i < 16; i++) rom[i] = $urandom;
    axis_rst = 1'b1; slv_clear = 1'b1;
    repeat (3) @(posedge axis_clk);
    #1 axis_rst = 1'b0; slv_clear = 1'b0;
    @(negedge axis_clk);
    check("reset_outputs", {cfg_busy, cfg_done, cfg_error, coef_idx, awaddr, awvalid, wdata,
                            wvalid, araddr, arvalid, rready}, 0);

    scenario("ready_len600", 600, 1'b0, 1'b1, -1, 0, 0, 0, -1, 1'b1);
    scenario("aw_before_w", int'($urandom_range(1, 5000)), 1'b0, 1'b1, -1, 0, 0, 3, -1, 1'b0);
    scenario("verify_corrupt5", 600, 1'b1, 1'b1, 5, 0, 0, 0, -1, 1'b1);
    scenario("idle_timeout", 600, 1'b0, 1'b0, -1, 0, 0, 0, -1, 1'b1);
    scenario("done_after20", 600, 1'b0, 1'b1, -1, 20, 0, 0, 5, 1'b1);
    scenario("done_timeout", 77, 1'b0, 1'b1, -1, 1000, 0, 0, -1, 1'b1);
    scenario("verify_ok", int'($urandom_range(1, 5000)), 1'b1, 1'b1, -1,
             int'($urandom_range(0, 5)), 0, 0, -1, 1'b1);
    scenario("slow_verify", 321, 1'b1, 1'b1, -1, 2, int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), -1, 1'b0);

    // Reset in the middle of the tap-3 write; the block must abort silently.
    slv_idle = 1'b1; slv_corrupt = -1; slv_done_after = 0; aw_delay = 0; w_delay = 0;
    clear_slave();
    pulses0 = done_pulses;
    @(negedge axis_clk);
    cfg_start = 1'b1; cfg_data_length = 600; cfg_verify = 1'b0;
    @(negedge axis_clk);
    cfg_start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge axis_clk);
      if (coef_idx == 4'd3) hit = 1'b1;
    end
    check("reach_tap3", hit, 1);
    axis_rst = 1'b1;
    @(negedge axis_clk);
    check("midrun_reset_outputs", {cfg_busy, cfg_done, cfg_error, coef_idx, awaddr, awvalid,
                                   wdata, wvalid, araddr, arvalid, rready}, 0);
    axis_rst = 1'b0;
    repeat (3) @(negedge axis_clk);
    check("no_done_after_reset", done_pulses - pulses0, 0);
    check("idle_after_reset", cfg_busy, 0);
    scenario("restart", 600, 1'b0, 1'b1, -1, 0, 0, 0, -1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
